// File: rtl/qpmm_result_collector.sv
// Collects results from a fixed-latency QPMM pipeline, reduces each to a canonical residue
// mod M and buffers it in an in-order FWFT FIFO, with credit-based issue flow control.
module qpmm_result_collector #(
  parameter int unsigned LAT   = 22,
  parameter int unsigned ZW    = 272,
  parameter int unsigned TW    = 8,
  parameter int unsigned DEPTH = 32,
  parameter logic [255:0] M    =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [TW-1:0]              issue_tag,
  input  logic [ZW-1:0]              z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [255:0]               out_data,
  output logic [TW-1:0]              out_tag,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_range,
  output logic                       err_overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned PadW = ZW + 1 - 256;

  localparam logic [ZW:0] M1 = {{PadW{1'b0}}, M};
  localparam logic [ZW:0] M2 = M1 << 1;
  localparam logic [ZW:0] M4 = M1 << 2;
  localparam logic [ZW:0] M8 = M1 << 3;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW:0]   DepthS = (CW + 1)'(DEPTH);

  // Compare and subtract at ZW+1 bits, keep the low 256 bits.
  function automatic logic [255:0] cond_sub(input logic [ZW:0] v, input logic [ZW:0] k);
    if (v >= k) return 256'(v - k);
    else        return 256'(v);
  endfunction

  logic fire;
  assign fire = issue_valid && issue_ready;

  // Issue-side delay line mirroring the QPMM pipeline
  logic [LAT-1:0] dly_vld_q;
  logic [TW-1:0]  dly_tag_q [LAT];
  logic           cap_fire;
  logic [TW-1:0]  cap_tag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_vld_q <= '0;
      for (int i = 0; i < LAT; i++) dly_tag_q[i] <= '0;
    end else begin
      dly_vld_q    <= {dly_vld_q[LAT-2:0], fire};
      dly_tag_q[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) dly_tag_q[i] <= dly_tag_q[i-1];
    end
  end

  assign cap_fire = dly_vld_q[LAT-1];
  assign cap_tag  = dly_tag_q[LAT-1];

  // Three-stage conditional-subtract reduction; stage 1 also captures z
  logic [ZW:0]    z_ext;
  logic           s1_vld_q, s2_vld_q, s3_vld_q;
  logic [255:0]   s1_data_q, s2_data_q, s3_data_q;
  logic [TW-1:0]  s1_tag_q, s2_tag_q, s3_tag_q;
  logic           err_range_q;

  assign z_ext = {1'b0, z};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      s1_vld_q <= cap_fire;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      if (cap_fire && (z_ext >= M8)) err_range_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_fire) begin
      s1_data_q <= cond_sub(z_ext, M4);
      s1_tag_q  <= cap_tag;
    end
    if (s1_vld_q) begin
      s2_data_q <= cond_sub({{PadW{1'b0}}, s1_data_q}, M2);
      s2_tag_q  <= s1_tag_q;
    end
    if (s2_vld_q) begin
      s3_data_q <= cond_sub({{PadW{1'b0}}, s2_data_q}, M1);
      s3_tag_q  <= s2_tag_q;
    end
  end

  // Output FIFO, first-word-fall-through from registered storage
  logic [255:0]  mem_data [DEPTH];
  logic [TW-1:0] mem_tag  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_overflow_q, err_overflow_d;
  logic          full, wr_en, rd_en;

  assign full  = (count_q == DepthC);
  assign rd_en = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = s3_vld_q && (!full || rd_en);

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    inflight_d     = inflight_q;
    err_overflow_d = err_overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({fire, s3_vld_q})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (s3_vld_q && full && !rd_en) err_overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      inflight_q     <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      inflight_q     <= inflight_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= s3_data_q;
      mem_tag[wr_ptr_q]  <= s3_tag_q;
    end
  end

  always_comb begin
    out_valid    = (count_q != '0);
    out_data     = out_valid ? mem_data[rd_ptr_q] : '0;
    out_tag      = out_valid ? mem_tag[rd_ptr_q]  : '0;
    fifo_level   = count_q;
    err_range    = err_range_q;
    err_overflow = err_overflow_q;
    // Credits count both buffered and in-flight results so nothing is ever dropped.
    issue_ready  = (({1'b0, inflight_q} + {1'b0, count_q}) < DepthS);
  end

endmodule
